// File: rtl/assoc_dcache_mt.sv
// assoc_dcache_mt: N-way set-associative, write-through, no-write-allocate L1 D-cache
// shared by THREADS harts. Blocking with one request in flight. Each set has its own
// round-robin replacement pointer. Completions are reported with the requesting hart ID.
//
// Ports:
//   clk, Reset (synchronous, active high)
//   request : load, store, mhartID_Mem, Address_Mem, WritetoData -> ReqReady, StoreHazard
//   result  : CacheHit, CacheMiss, WriteBackData, DoneForTIDValid/DoneForTID,
//             WrDoneValid/DoneWritingFor
//   memory  : RamRead/RamReadAddress/RamData/DoneReadingData,
//             RamWrite/RamWriteAddress/RamWriteData/DoneWritingData
// Optional build macro DCACHE_PERF_CNT_EN adds the per-hart HitCount/MissCount outputs.
// These are saturating load hit/miss counters.
//
// state  | meaning
// IDLE   | ready; capture request and read all ways of the set
// LOOKUP | tag compare; load hit returns data, store updates a hit way
// REFILL | read word from RAM, install into victim way
// WTHRU  | write word to RAM

module assoc_dcache_mt #(
    parameter int  WAYS    = 2,
    parameter int  SETS    = 128,
    parameter int  THREADS = 4,
    parameter int  ADDR_W  = 32,
    localparam int TID_W   = (THREADS > 1) ? $clog2(THREADS) : 1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              load,
    input  logic              store,
    input  logic [TID_W-1:0]  mhartID_Mem,
    input  logic [ADDR_W-1:0] Address_Mem,
    input  logic [31:0]       WritetoData,
    output logic              ReqReady,
    output logic              CacheHit,
    output logic              CacheMiss,
    output logic              StoreHazard,
    output logic [31:0]       WriteBackData,
    output logic              DoneForTIDValid,
    output logic [TID_W-1:0]  DoneForTID,
    output logic [TID_W-1:0]  DoneWritingFor,
    output logic              WrDoneValid,
    output logic              RamRead,
    output logic [ADDR_W-1:0] RamReadAddress,
    input  logic [31:0]       RamData,
    input  logic              DoneReadingData,
    output logic              RamWrite,
    output logic [ADDR_W-1:0] RamWriteAddress,
    output logic [31:0]       RamWriteData,
    input  logic              DoneWritingData
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]       HitCount  [THREADS],
    output logic [31:0]       MissCount [THREADS]
`endif
);
    localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int TAG_W = ADDR_W - 2 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_WTHRU} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [TID_W-1:0]  tid_q, tid_d;
    logic              is_store_q, is_store_d;

    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [31:0]       data_mem [WAYS][SETS];
    logic [WAYS-1:0]   valid_q  [SETS];
    logic [WAYS-1:0]   valid_d  [SETS];
    logic [WAY_W-1:0]  rr_q     [SETS];
    logic [WAY_W-1:0]  rr_d     [SETS];

    logic [TAG_W-1:0]  rd_tag_q  [WAYS];
    logic [TAG_W-1:0]  rd_tag_d  [WAYS];
    logic [31:0]       rd_data_q [WAYS];
    logic [31:0]       rd_data_d [WAYS];
    logic [WAYS-1:0]   rd_valid_q, rd_valid_d;

    logic              ready_q, ready_d, hit_q, hit_d, miss_q, miss_d;
    logic              done_q, done_d, wr_done_q, wr_done_d, ram_rd_q, ram_rd_d, ram_wr_q, ram_wr_d;
    logic [31:0]       wb_data_q, wb_data_d, ram_wr_data_q, ram_wr_data_d;
    logic [TID_W-1:0]  done_tid_q, done_tid_d, wr_tid_q, wr_tid_d;
    logic [ADDR_W-1:0] ram_rd_addr_q, ram_rd_addr_d, ram_wr_addr_q, ram_wr_addr_d;

    logic              accept, hit, victim_free, mem_we, tag_we;
    logic [WAY_W-1:0]  hit_way, victim, we_way;
    logic [31:0]       hit_data, we_data;
    logic [IDX_W-1:0]  in_idx, lk_idx;
    logic [TAG_W-1:0]  lk_tag;

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q [THREADS], hit_cnt_d [THREADS];
    logic [31:0] miss_cnt_q [THREADS], miss_cnt_d [THREADS];
    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;
`endif

    // ready_q is only ever set while IDLE, so it doubles as the acceptance gate
    assign accept = (load | store) & ready_q;
    assign in_idx = Address_Mem[2 +: IDX_W];
    assign lk_idx = addr_q[2 +: IDX_W];
    assign lk_tag = addr_q[ADDR_W-1 -: TAG_W];

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (rd_valid_q[w] && rd_tag_q[w] == lk_tag) begin
                hit      = 1'b1;
                hit_way  = WAY_W'(w);
                hit_data = rd_data_q[w];
            end
        end
        // lowest invalid way wins; otherwise the set's round-robin pointer
        victim_free = 1'b0;
        victim      = rr_q[lk_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_free && !valid_q[lk_idx][w]) begin
                victim_free = 1'b1;
                victim      = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tid_d      = tid_q;
        is_store_d = is_store_q;
        valid_d    = valid_q;
        rr_d       = rr_q;
        rd_tag_d   = rd_tag_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        hit_d      = 1'b0;
        done_d     = 1'b0;
        wr_done_d  = 1'b0;
        wb_data_d  = wb_data_q;
        done_tid_d = done_tid_q;
        wr_tid_d   = wr_tid_q;
        mem_we     = 1'b0;
        tag_we     = 1'b0;
        we_way     = '0;
        we_data    = '0;
`ifdef DCACHE_PERF_CNT_EN
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
`endif
        case (state_q)
            S_IDLE: if (accept) begin
                state_d    = S_LOOKUP;
                addr_d     = Address_Mem;
                wdata_d    = WritetoData;
                tid_d      = mhartID_Mem;
                is_store_d = store;      // store wins if both are raised
                for (int w = 0; w < WAYS; w++) begin
                    rd_tag_d[w]   = tag_mem[w][in_idx];
                    rd_data_d[w]  = data_mem[w][in_idx];
                    rd_valid_d[w] = valid_q[in_idx][w];
                end
            end
            S_LOOKUP: begin
                if (is_store_q) begin
                    state_d = S_WTHRU;
                    mem_we  = hit;
                    we_way  = hit_way;
                    we_data = wdata_q;
                end else if (hit) begin
                    state_d   = S_IDLE;
                    hit_d     = 1'b1;
                    wb_data_d = hit_data;
                end else begin
                    state_d = S_REFILL;
                end
`ifdef DCACHE_PERF_CNT_EN
                if (!is_store_q && hit && hit_cnt_q[tid_q] != '1)
                    hit_cnt_d[tid_q] = hit_cnt_q[tid_q] + 32'd1;
                if (!is_store_q && !hit && miss_cnt_q[tid_q] != '1)
                    miss_cnt_d[tid_q] = miss_cnt_q[tid_q] + 32'd1;
`endif
            end
            S_REFILL: if (DoneReadingData) begin
                state_d                 = S_IDLE;
                mem_we                  = 1'b1;
                tag_we                  = 1'b1;
                we_way                  = victim;
                we_data                 = RamData;
                valid_d[lk_idx][victim] = 1'b1;
                if (!victim_free)
                    rr_d[lk_idx] = (rr_q[lk_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[lk_idx] + 1'b1;
                done_d     = 1'b1;
                done_tid_d = tid_q;
                wb_data_d  = RamData;
            end
            S_WTHRU: if (DoneWritingData) begin
                state_d   = S_IDLE;
                wr_done_d = 1'b1;
                wr_tid_d  = tid_q;
            end
            default: state_d = S_IDLE;
        endcase
        ready_d       = (state_d == S_IDLE);
        miss_d        = (state_d == S_REFILL) || (state_d == S_WTHRU);
        ram_rd_d      = (state_d == S_REFILL);
        ram_wr_d      = (state_d == S_WTHRU);
        ram_rd_addr_d = ram_rd_d ? (addr_q & ~ADDR_W'(3)) : '0;
        ram_wr_addr_d = ram_wr_d ? (addr_q & ~ADDR_W'(3)) : '0;
        ram_wr_data_d = ram_wr_d ? wdata_q : '0;
    end

    // storage arrays and their registered read ports carry no reset
    always_ff @(posedge clk) begin
        if (mem_we && !Reset) data_mem[we_way][lk_idx] <= we_data;
        if (tag_we && !Reset) tag_mem[we_way][lk_idx]  <= lk_tag;
        rd_tag_q  <= rd_tag_d;
        rd_data_q <= rd_data_d;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            tid_q         <= '0;
            is_store_q    <= 1'b0;
            rd_valid_q    <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
            {ready_q, hit_q, miss_q, done_q, wr_done_q, ram_rd_q, ram_wr_q} <= '0;
            wb_data_q     <= '0;
            done_tid_q    <= '0;
            wr_tid_q      <= '0;
            ram_rd_addr_q <= '0;
            ram_wr_addr_q <= '0;
            ram_wr_data_q <= '0;
`ifdef DCACHE_PERF_CNT_EN
            for (int t = 0; t < THREADS; t++) begin
                hit_cnt_q[t]  <= '0;
                miss_cnt_q[t] <= '0;
            end
`endif
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            tid_q         <= tid_d;
            is_store_q    <= is_store_d;
            rd_valid_q    <= rd_valid_d;
            valid_q       <= valid_d;
            rr_q          <= rr_d;
            {ready_q, hit_q, miss_q, done_q, wr_done_q, ram_rd_q, ram_wr_q} <=
                {ready_d, hit_d, miss_d, done_d, wr_done_d, ram_rd_d, ram_wr_d};
            wb_data_q     <= wb_data_d;
            done_tid_q    <= done_tid_d;
            wr_tid_q      <= wr_tid_d;
            ram_rd_addr_q <= ram_rd_addr_d;
            ram_wr_addr_q <= ram_wr_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
`ifdef DCACHE_PERF_CNT_EN
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
`endif
        end
    end

    assign ReqReady        = ready_q;
    assign StoreHazard     = (load | store) & ~ready_q & ~Reset;
    assign CacheHit        = hit_q;
    assign CacheMiss       = miss_q;
    assign WriteBackData   = wb_data_q;
    assign DoneForTIDValid = done_q;
    assign DoneForTID      = done_tid_q;
    assign WrDoneValid     = wr_done_q;
    assign DoneWritingFor  = wr_tid_q;
    assign RamRead         = ram_rd_q;
    assign RamReadAddress  = ram_rd_addr_q;
    assign RamWrite        = ram_wr_q;
    assign RamWriteAddress = ram_wr_addr_q;
    assign RamWriteData    = ram_wr_data_q;

    a_no_load_and_store: assert property (@(posedge clk) disable iff (Reset) !(load && store));

endmodule

// File: tb/tb_assoc_dcache_mt.sv
// Testbench for assoc_dcache_mt (WAYS=2, SETS=128, THREADS=4).
// Directed load/store sequences are applied to the cache. A set-level cache model
// predicts hit or miss, the victim way and the returned data. The expected output
// levels for every cycle are derived from that model.
module tb_assoc_dcache_mt;
    localparam int WAYS = 2, SETS = 128, IDX_W = 7;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        Reset, load, store, DoneReadingData, DoneWritingData;
    logic [1:0]  mhartID_Mem;
    logic [31:0] Address_Mem, WritetoData, RamData;
    logic        ReqReady, CacheHit, CacheMiss, StoreHazard, DoneForTIDValid, WrDoneValid;
    logic        RamRead, RamWrite;
    logic [1:0]  DoneForTID, DoneWritingFor;
    logic [31:0] WriteBackData, RamReadAddress, RamWriteAddress, RamWriteData;

    assoc_dcache_mt dut (
        .clk(clk), .Reset(Reset), .load(load), .store(store), .mhartID_Mem(mhartID_Mem),
        .Address_Mem(Address_Mem), .WritetoData(WritetoData), .ReqReady(ReqReady),
        .CacheHit(CacheHit), .CacheMiss(CacheMiss), .StoreHazard(StoreHazard),
        .WriteBackData(WriteBackData), .DoneForTIDValid(DoneForTIDValid), .DoneForTID(DoneForTID),
        .DoneWritingFor(DoneWritingFor), .WrDoneValid(WrDoneValid), .RamRead(RamRead),
        .RamReadAddress(RamReadAddress), .RamData(RamData), .DoneReadingData(DoneReadingData),
        .RamWrite(RamWrite), .RamWriteAddress(RamWriteAddress), .RamWriteData(RamWriteData),
        .DoneWritingData(DoneWritingData)
    );

    int n_chk = 0, n_fail = 0;
    logic chk_en = 1'b0;
    logic e_ready = 0, e_hit = 0, e_miss = 0, e_done = 0, e_wrdone = 0, e_rd = 0, e_wr = 0, e_zero = 0;
    logic [31:0] e_wb = 0, e_rdaddr = 0, e_wraddr = 0, e_wrdata = 0;
    logic [1:0]  e_tid = 0, e_wtid = 0;

    // cache model: contents per set/way plus the round-robin pointer
    logic        mv [WAYS][SETS];
    logic [22:0] mt [WAYS][SETS];
    logic [31:0] md [WAYS][SETS];
    int          mrr [SETS];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_way(input logic [31:0] a);
        int s = int'(a[2 +: IDX_W]);
        for (int w = 0; w < WAYS; w++)
            if (mv[w][s] && mt[w][s] == a[31:9]) return w;
        return -1;
    endfunction

    task automatic m_reset();
        for (int s = 0; s < SETS; s++) begin
            mrr[s] = 0;
            for (int w = 0; w < WAYS; w++) mv[w][s] = 1'b0;
        end
    endtask

    task automatic m_fill(input logic [31:0] a, input logic [31:0] d);
        int s = int'(a[2 +: IDX_W]);
        int v = -1;
        for (int w = 0; w < WAYS; w++) if (v < 0 && !mv[w][s]) v = w;
        if (v < 0) begin
            v = mrr[s];
            mrr[s] = (mrr[s] + 1) % WAYS;
        end
        mv[v][s] = 1'b1;
        mt[v][s] = a[31:9];
        md[v][s] = d;
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("ReqReady", ReqReady, e_ready);
        chk("StoreHazard", StoreHazard, (load | store) & ~e_ready & ~Reset);
        chk("CacheHit", CacheHit, e_hit);
        chk("CacheMiss", CacheMiss, e_miss);
        chk("DoneForTIDValid", DoneForTIDValid, e_done);
        chk("WrDoneValid", WrDoneValid, e_wrdone);
        chk("RamRead", RamRead, e_rd);
        chk("RamWrite", RamWrite, e_wr);
        if (e_rd) chk("RamReadAddress", RamReadAddress, e_rdaddr);
        if (e_wr) begin
            chk("RamWriteAddress", RamWriteAddress, e_wraddr);
            chk("RamWriteData", RamWriteData, e_wrdata);
        end
        if (e_hit || e_done) chk("WriteBackData", WriteBackData, e_wb);
        if (e_done) chk("DoneForTID", DoneForTID, e_tid);
        if (e_wrdone) chk("DoneWritingFor", DoneWritingFor, e_wtid);
        if (e_zero) begin
            chk("rst_WriteBackData", WriteBackData, 0);
            chk("rst_RamReadAddress", RamReadAddress, 0);
            chk("rst_RamWriteAddress", RamWriteAddress, 0);
            chk("rst_RamWriteData", RamWriteData, 0);
            chk("rst_DoneForTID", DoneForTID, 0);
            chk("rst_DoneWritingFor", DoneWritingFor, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // starts with the DUT idle and ready, #1 after a posedge; returns the same way
    task automatic do_load(input logic [1:0] tid, input logic [31:0] a, input logic [31:0] rd,
                           input int lat, input bit hz);
        int w = m_way(a);
        load = 1; mhartID_Mem = tid; Address_Mem = a; e_ready = 1;
        tick();
        load = 0; e_ready = 0;
        tick();
        if (w >= 0) begin
            e_hit = 1; e_wb = md[w][a[2 +: IDX_W]]; e_ready = 1;
            tick();
            e_hit = 0;
        end else begin
            e_miss = 1; e_rd = 1; e_rdaddr = {a[31:2], 2'b00};
            for (int i = 0; i < lat; i++) begin
                if (hz) begin
                    load = 1; mhartID_Mem = 2'd1; Address_Mem = 32'h0000_0ABC;
                end
                tick();
            end
            load = 0; DoneReadingData = 1; RamData = rd;
            tick();
            DoneReadingData = 0; RamData = 32'h0;
            e_done = 1; e_tid = tid; e_wb = rd; e_ready = 1; e_miss = 0; e_rd = 0;
            m_fill(a, rd);
            tick();
            e_done = 0;
        end
    endtask

    task automatic do_store(input logic [1:0] tid, input logic [31:0] a, input logic [31:0] d,
                            input int lat);
        int w = m_way(a);
        store = 1; mhartID_Mem = tid; Address_Mem = a; WritetoData = d; e_ready = 1;
        tick();
        store = 0; e_ready = 0;
        if (w >= 0) md[w][a[2 +: IDX_W]] = d;
        tick();
        e_miss = 1; e_wr = 1; e_wraddr = {a[31:2], 2'b00}; e_wrdata = d;
        repeat (lat) tick();
        DoneWritingData = 1;
        tick();
        DoneWritingData = 0;
        e_wrdone = 1; e_wtid = tid; e_ready = 1; e_miss = 0; e_wr = 0;
        tick();
        e_wrdone = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        Reset = 1; load = 0; store = 0; mhartID_Mem = 0; Address_Mem = 0; WritetoData = 0;
        RamData = 0; DoneReadingData = 0; DoneWritingData = 0;
        m_reset();
        tick();
        chk_en = 1; e_zero = 1;
        tick();
        tick();
        Reset = 0;
        tick();
        e_zero = 0; e_ready = 1;
        tick();

        // fill then hit
        do_load(2'd0, 32'h100, 32'hDEADBEEF, 3, 0);
        chk("pin_fill_0x100_way0", m_way(32'h100), 0);
        do_load(2'd0, 32'h100, 32'h0, 1, 0);

        // store hit updates the line and writes through
        do_store(2'd2, 32'h100, 32'h12345678, 2);
        chk("pin_store_data", md[0][64], 32'h12345678);
        do_load(2'd3, 32'h100, 32'h0, 1, 0);

        // three lines in set 0, third evicts way0 and advances the pointer
        do_load(2'd0, 32'h000, 32'hA0A0A0A0, 1, 0);
        do_load(2'd1, 32'h200, 32'hA1A1A1A1, 2, 0);
        do_load(2'd2, 32'h400, 32'hA2A2A2A2, 1, 0);
        chk("pin_evict_0x000", m_way(32'h000) == -1, 1);
        chk("pin_0x400_way0", m_way(32'h400), 0);
        chk("pin_rr_set0", mrr[0], 1);
        do_load(2'd1, 32'h200, 32'h0, 1, 0);
        do_load(2'd0, 32'h000, 32'hB0B0B0B0, 2, 0);

        // store miss: write-through only, no allocation
        do_store(2'd1, 32'h300, 32'h0BADF00D, 3);
        chk("pin_no_alloc_0x300", m_way(32'h300) == -1, 1);
        do_load(2'd1, 32'h300, 32'h33333333, 1, 0);

        // second hart's load is stalled for the whole refill
        do_load(2'd3, 32'h500, 32'h55555555, 4, 1);

        // reset in the middle of a refill, late completion afterwards
        load = 1; mhartID_Mem = 2'd0; Address_Mem = 32'h600; e_ready = 1;
        tick();
        load = 0; e_ready = 0;
        tick();
        e_miss = 1; e_rd = 1; e_rdaddr = 32'h600;
        tick();
        tick();
        Reset = 1;
        tick();
        e_miss = 0; e_rd = 0; e_zero = 1;
        Reset = 0; DoneReadingData = 1; RamData = 32'hBAD0BAD0;
        m_reset();
        tick();
        DoneReadingData = 0; RamData = 0; e_zero = 0; e_ready = 1;
        chk("pin_rst_RamRead", RamRead, 0);
        tick();
        do_load(2'd2, 32'h103, 32'hCAFEF00D, 2, 0);
        do_load(2'd2, 32'h100, 32'h0, 1, 0);

        tick();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
